// File: rtl/bp_pkg.sv
// Shared branch-prediction types and widths used by fetch, the resolve queue and the
// gshare predictor wrappers.
package bp_pkg;

   localparam int PC_W    = 32;
   localparam int IDX_W   = 8;
   localparam int IDX_LSB = 2;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
   } bp_entry_t;

   // Fall-through fetch address of a branch, wrapping modulo 2^PC_W.
   function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(4);
   endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-update signal bundle of the branch resolve queue.
interface branch_resolve_queue_if
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             fq_push;
   logic [PC_W-1:0]  fq_pc;
   logic             fq_pred_taken;
   logic [PC_W-1:0]  fq_pred_target;
   logic             fq_full;
   logic             ex_resolve;
   logic             ex_taken;
   logic [PC_W-1:0]  ex_target;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_addr;
   logic             upd_taken;
   logic             flush;
   logic [PC_W-1:0]  redirect_pc;
   logic [CNT_W-1:0] count;
   logic             underflow_err;

   modport master (
      output fq_push, fq_pc, fq_pred_taken, fq_pred_target,
      output ex_resolve, ex_taken, ex_target,
      input  fq_full, upd_valid, upd_addr, upd_taken, flush, redirect_pc, count, underflow_err
   );

   modport slave (
      input  fq_push, fq_pc, fq_pred_taken, fq_pred_target,
      input  ex_resolve, ex_taken, ex_target,
      output fq_full, upd_valid, upd_addr, upd_taken, flush, redirect_pc, count, underflow_err
   );

endinterface

// File: rtl/bp_fifo.sv
// Circular in-order storage for in-flight predicted branches. The caller qualifies
// push/pop; clear wins over both and drops any simultaneous push.
module bp_fifo
   import bp_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  bp_entry_t        push_data_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output bp_entry_t        head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   bp_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      if (clear_i) begin
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q;
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds fetch-predicted branches until execute resolves them in order; emits predictor
// update pulses and, on a misprediction, a flush with the corrected fetch PC.
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input logic                   clk,
   input logic                   rst_n,
   branch_resolve_queue_if.slave bus
);

   bp_entry_t        push_data_s;
   bp_entry_t        head_s;
   logic [CNT_W-1:0] count_s;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             mispredict_s;
   logic             push_s;

   logic             upd_valid_q, upd_valid_d;
   logic [IDX_W-1:0] upd_addr_q, upd_addr_d;
   logic             upd_taken_q, upd_taken_d;
   logic             flush_q, flush_d;
   logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
   logic             underflow_q, underflow_d;

   assign push_data_s = '{pc: bus.fq_pc, pred_taken: bus.fq_pred_taken,
                          pred_target: bus.fq_pred_target};

   assign pop_s        = bus.ex_resolve && !empty_s;
   assign mispredict_s = pop_s && ((head_s.pred_taken != bus.ex_taken) ||
                                   (bus.ex_taken && (head_s.pred_target != bus.ex_target)));
   // A pop frees a slot at full; a flush kills whatever fetch offers this cycle.
   assign push_s       = bus.fq_push && (!full_s || pop_s) && !mispredict_s;

   bp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .clear_i     (mispredict_s),
      .head_o      (head_s),
      .count_o     (count_s),
      .full_o      (full_s),
      .empty_o     (empty_s)
   );

   always_comb begin
      upd_valid_d = pop_s;
      flush_d     = mispredict_s;
      underflow_d = underflow_q | (bus.ex_resolve && empty_s);
      if (pop_s) begin
         upd_addr_d  = head_s.pc[IDX_LSB +: IDX_W];
         upd_taken_d = bus.ex_taken;
      end else begin
         upd_addr_d  = upd_addr_q;
         upd_taken_d = upd_taken_q;
      end
      if (mispredict_s) begin
         redirect_pc_d = bus.ex_taken ? bus.ex_target : next_seq_pc(head_s.pc);
      end else begin
         redirect_pc_d = redirect_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         upd_valid_q   <= 1'b0;
         upd_addr_q    <= {IDX_W{1'b0}};
         upd_taken_q   <= 1'b0;
         flush_q       <= 1'b0;
         redirect_pc_q <= {PC_W{1'b0}};
         underflow_q   <= 1'b0;
      end else begin
         upd_valid_q   <= upd_valid_d;
         upd_addr_q    <= upd_addr_d;
         upd_taken_q   <= upd_taken_d;
         flush_q       <= flush_d;
         redirect_pc_q <= redirect_pc_d;
         underflow_q   <= underflow_d;
      end
   end

   assign bus.fq_full       = full_s;
   assign bus.count         = count_s;
   assign bus.upd_valid     = upd_valid_q;
   assign bus.upd_addr      = upd_addr_q;
   assign bus.upd_taken     = upd_taken_q;
   assign bus.flush         = flush_q;
   assign bus.redirect_pc   = redirect_pc_q;
   assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench: a queue-based reference model predicts update pulses and state,
// a separate negedge monitor compares them against the DUT.
module tb_branch_resolve_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ptgt;
   } ment_t;

   typedef struct {
      logic [7:0] addr;
      logic       taken;
      logic       flush;
   } exp_t;

   logic clk;
   logic rst_n;

   ment_t       mq[$];
   exp_t        exp_q[$];
   logic        uf_m;
   logic [31:0] redir_m;
   int          n_vec;
   int          n_err;

   branch_resolve_queue_if #(.DEPTH(DEPTH)) bif ();

   branch_resolve_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain in-order list of branches, evaluated once per rising edge.
   task automatic model_step();
      ment_t e;
      exp_t  x;
      logic  mis;
      mis = 1'b0;
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         uf_m    = 1'b0;
         redir_m = 32'h0;
      end else begin
         if (bif.ex_resolve) begin
            if (mq.size() == 0) begin
               uf_m = 1'b1;
            end else begin
               e   = mq.pop_front();
               mis = (e.pt != bif.ex_taken) || (bif.ex_taken && (e.ptgt != bif.ex_target));
               x.addr  = e.pc[9:2];
               x.taken = bif.ex_taken;
               x.flush = mis;
               exp_q.push_back(x);
               if (mis) begin
                  redir_m = bif.ex_taken ? bif.ex_target : e.pc + 32'd4;
                  mq.delete();
               end
            end
         end
         if (bif.fq_push && !mis && (mq.size() < DEPTH)) begin
            e.pc   = bif.fq_pc;
            e.pt   = bif.fq_pred_taken;
            e.ptgt = bif.fq_pred_target;
            mq.push_back(e);
         end
      end
   endtask

   task automatic monitor_step();
      exp_t x;
      chk("count", 32'(bif.count), 32'(mq.size()));
      chk("fq_full", 32'(bif.fq_full), 32'(mq.size() == DEPTH));
      chk("underflow_err", 32'(bif.underflow_err), 32'(uf_m));
      chk("redirect_pc", bif.redirect_pc, redir_m);
      if (exp_q.size() != 0) begin
         x = exp_q.pop_front();
         chk("upd_valid", 32'(bif.upd_valid), 32'd1);
         chk("upd_addr", 32'(bif.upd_addr), 32'(x.addr));
         chk("upd_taken", 32'(bif.upd_taken), 32'(x.taken));
         chk("flush", 32'(bif.flush), 32'(x.flush));
      end else begin
         chk("upd_valid_idle", 32'(bif.upd_valid), 32'd0);
         chk("flush_idle", 32'(bif.flush), 32'd0);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      monitor_step();
   end

   task automatic drive(input logic push, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptgt, input logic res, input logic tk,
                        input logic [31:0] tgt);
      bif.fq_push        = push;
      bif.fq_pc          = pc;
      bif.fq_pred_taken  = pt;
      bif.fq_pred_target = ptgt;
      bif.ex_resolve     = res;
      bif.ex_taken       = tk;
      bif.ex_target      = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic        rp, rr, rtk;
      logic [31:0] rtgt;
      n_vec   = 0;
      n_err   = 0;
      uf_m    = 1'b0;
      redir_m = 32'h0;
      rst_n   = 1'b0;

      // Reset held two cycles with fetch pushing
      drive(1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
      idle(1);

      // Correctly predicted taken branch
      drive(1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h180);
      idle(2);

      // Direction mispredicts both ways, plus PC wrap on fall-through
      drive(1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
      drive(1'b1, 32'h204, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      // Target mispredict: same direction, different target
      drive(1'b1, 32'h3F0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h504);
      idle(1);

      // Fill, drop a push at full, push+pop at full across pointer wrap, drain
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 32'hDEAD_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h2000 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(1);

      // Mispredict with three queued and a simultaneous push
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600);
      idle(2);

      // Resolve on empty: sticky underflow, cleared only by reset
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(3);
      drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      drive(1'b1, 32'h704, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      rst_n = 1'b1;
      idle(1);

      // Randomized traffic, mostly correct predictions so the queue fills
      for (int c = 0; c < 800; c++) begin
         rp  = ($urandom_range(0, 1) == 1);
         rr  = ($urandom_range(0, 9) < 4);
         rtk = 1'($urandom_range(0, 1));
         rtgt = ($urandom_range(0, 1) == 1) ? 32'h8000 : 32'h9000;
         if ((mq.size() != 0) && ($urandom_range(0, 7) != 0)) begin
            rtk  = mq[0].pt;
            rtgt = mq[0].ptgt;
         end
         if (c == 400) rst_n = 1'b0;
         else rst_n = 1'b1;
         drive(rp, $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? 32'h8000 : 32'h9000, rr, rtk, rtgt);
      end
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(3);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
